// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest digit count d with 10^d > 2^width-1, so every input fits.
    function automatic int min_digits(input int width);
        longint unsigned maxv;
        longint unsigned p;
        int              d;
        maxv = (64'd1 << width) - 64'd1;
        p    = 64'd10;
        d    = 1;
        while (p <= maxv) begin
            p = p * 64'd10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result handshake between the converter and its producer/consumer.
interface bin2bcd_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, busy
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, busy
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per cycle.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic      clk,
    input  logic      rst,
    bin2bcd_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 4 * DIGITS;

    generate
        if (WIDTH < 1 || DIGITS < min_digits(WIDTH)) begin : g_bad_cfg
            $error("bin2bcd_seq: DIGITS too small for WIDTH, or WIDTH < 1");
        end
    endgenerate

    state_t              state;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       adj;
    logic [AW-1:0]       bcd_q;
    logic [WIDTH-1:0]    sr;
    logic [CW-1:0]       cnt;
    logic [AW+WIDTH-1:0] shifted;
    logic                in_ready_q;
    logic                busy_q;
    logic                out_valid_q;

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (acc[4*d +: 4]),
                .dout (adj[4*d +: 4])
            );
        end
    endgenerate

    // Corrected accumulator and remaining input bits move left together.
    assign shifted = {adj, sr} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            sr          <= '0;
            cnt         <= '0;
            bcd_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sr         <= bus.bin;
                        acc        <= '0;
                        cnt        <= CW'(WIDTH);
                        state      <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc <= shifted[AW+WIDTH-1:WIDTH];
                    sr  <= shifted[WIDTH-1:0];
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        bcd_q       <= shifted[AW+WIDTH-1:WIDTH];
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd       = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks of bin2bcd_seq at 8-bit/3-digit and 16-bit/5-digit.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] prev8;

    always #5 clk = ~clk;

    bin2bcd_if #(.WIDTH(8),  .DIGITS(3)) bus8  ();
    bin2bcd_if #(.WIDTH(16), .DIGITS(5)) bus16 ();

    bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    // Decimal digits by division, one nibble per digit.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [7:0] b, input int hold, input string tag);
        int          n;
        logic [31:0] exp;
        exp = ref_bcd(32'(b), 3);
        n = 0;
        while (!bus8.in_ready && n < 50) begin step(); n++; end
        chk({tag, " ready"}, 32'(bus8.in_ready), 32'd1);
        bus8.bin       = b;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = (hold == 0);
        step();
        bus8.in_valid = 1'b0;
        chk({tag, " busy"}, 32'(bus8.busy), 32'd1);
        chk({tag, " keep_prev"}, 32'(bus8.bcd), prev8);
        n = 0;
        while (!bus8.out_valid && n < 40) begin step(); n++; end
        chk({tag, " latency"}, 32'(n), 32'd8);
        chk({tag, " bcd"}, 32'(bus8.bcd), exp);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, " hold_valid"}, {30'd0, bus8.out_valid, bus8.in_ready}, 32'd2);
            chk({tag, " hold_bcd"}, 32'(bus8.bcd), exp);
        end
        bus8.out_ready = 1'b1;
        step();
        chk({tag, " released"}, {30'd0, bus8.out_valid, bus8.in_ready}, 32'd1);
        prev8 = exp;
    endtask

    task automatic run16(input logic [15:0] b, input string tag);
        int n;
        bus16.bin       = b;
        bus16.in_valid  = 1'b1;
        bus16.out_ready = 1'b1;
        step();
        bus16.in_valid = 1'b0;
        n = 0;
        while (!bus16.out_valid && n < 60) begin step(); n++; end
        chk({tag, " latency"}, 32'(n), 32'd16);
        chk({tag, " bcd"}, 32'(bus16.bcd), ref_bcd(32'(b), 5));
        step();
        chk({tag, " released"}, 32'(bus16.in_ready), 32'd1);
    endtask

    initial begin
        int n;
        int extra;
        rst             = 1'b1;
        bus8.in_valid   = 1'b0;
        bus8.bin        = '0;
        bus8.out_ready  = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.bin       = '0;
        bus16.out_ready = 1'b0;
        prev8           = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset8", {19'd0, bus8.in_ready, bus8.busy, bus8.out_valid, bus8.bcd}, {19'd0, 3'b100, 12'h000});
        chk("reset16", {9'd0, bus16.in_ready, bus16.busy, bus16.out_valid, bus16.bcd}, {9'd0, 3'b100, 20'h00000});

        // Idle out_ready must not disturb anything.
        bus8.out_ready = 1'b1;
        step();
        chk("idle_out_ready", {30'd0, bus8.in_ready, bus8.out_valid}, 32'd2);

        run8(8'd0,   0, "zero");
        run8(8'd255, 0, "max");
        run8(8'd99,  0, "n99");
        run8(8'd100, 0, "n100");
        run8(8'd77,  5, "backpressure");

        // Input offered mid-conversion is ignored.
        bus8.bin = 8'd42; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        step(); step();
        bus8.bin = 8'd7; bus8.in_valid = 1'b1;
        step(); step();
        chk("ignore_busy", {30'd0, bus8.busy, bus8.in_ready}, 32'd2);
        bus8.in_valid = 1'b0; bus8.bin = '0;
        n = 0;
        while (!bus8.out_valid && n < 40) begin step(); n++; end
        chk("ignore_bcd", 32'(bus8.bcd), 32'h042);
        step();
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            extra += int'(bus8.out_valid) + int'(!bus8.in_ready);
            step();
        end
        chk("ignore_no_extra", 32'(extra), 32'd0);
        prev8 = 32'h042;

        // Reset in the middle of a conversion aborts it.
        bus8.bin = 8'd200; bus8.in_valid = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_state", {19'd0, bus8.in_ready, bus8.busy, bus8.out_valid, bus8.bcd}, {19'd0, 3'b100, 12'h000});
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            extra += int'(bus8.out_valid);
            step();
        end
        chk("abort_no_valid", 32'(extra), 32'd0);
        prev8 = '0;
        run8(8'd13, 0, "after_abort");

        run16(16'd65535, "w16_max");
        for (int i = 0; i < 4; i++) run16(16'($urandom), "w16_rand");

        for (int v = 0; v < 256; v++) run8(8'(v), 0, $sformatf("sweep%0d", v));
        for (int i = 0; i < 8; i++) run8(8'($urandom), int'($urandom_range(0, 3)), "rand_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the binary input (count value from the counter stage).
REQ-002 Parameter DIGITS, default 3: number of BCD output digits.
REQ-003 clk  input  1  clock; single clock domain, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  bin holds a value to convert.
REQ-006 in_ready  output  1  block can accept a new value.
REQ-007 bin  input  WIDTH  unsigned binary value to convert.
REQ-008 out_valid  output  1  bcd holds a completed result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
REQ-011 busy  output  1  conversion in progress (state SHIFT).

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 exactly when the state is IDLE; busy SHALL be 1 exactly in SHIFT; out_valid SHALL be 1 exactly in DONE.
REQ-014 In IDLE, an edge with in_valid=1 SHALL capture bin into the shift register, clear the BCD accumulator, load the iteration counter with WIDTH, and move to SHIFT.
REQ-015 Each SHIFT cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one bit, and decrement the iteration counter.
REQ-016 After exactly WIDTH SHIFT edges the state SHALL become DONE, so out_valid first rises WIDTH cycles after the accept edge.
REQ-017 In DONE, bcd SHALL hold stable until an edge with out_ready=1, which SHALL return the state to IDLE.
REQ-018 out_ready=1 on the first DONE cycle SHALL give a one-cycle out_valid pulse; a new input is accepted no earlier than the following IDLE cycle.
REQ-019 in_valid asserted in SHIFT or DONE SHALL be ignored, and the state and data SHALL be unchanged.
REQ-020 out_ready asserted outside DONE SHALL have no effect.
REQ-021 bcd SHALL retain the last result in IDLE and SHIFT; the accumulator is internal and is not exposed until DONE.
REQ-022 Every digit of bcd SHALL be in the range 0-9 for every bin in [0, 2^WIDTH-1].
REQ-023 The iteration counter SHALL be $clog2(WIDTH+1) bits wide, and all arithmetic SHALL be unsigned with no overflow out of the top digit.
REQ-024 Elaboration SHALL fail if 10^DIGITS <= 2^WIDTH-1, or if WIDTH < 1.

Reset
REQ-025 rst=1 SHALL force IDLE, bcd=0, the accumulator, shift register and iteration counter to 0, out_valid=0, busy=0 and in_ready=1 on the next edge.
REQ-026 rst asserted during SHIFT or DONE SHALL abort the conversion without producing an out_valid pulse.
REQ-027 rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-028 Package bin2bcd_pkg SHALL hold the state enum typedef (IDLE, SHIFT, DONE) and a constant function computing the minimum DIGITS for a given WIDTH.
REQ-029 Sub-module bcd_digit_adj (combinational, 4-bit in and out, add 3 if >= 5) SHALL be instantiated once per digit via generate.
REQ-030 The FSM, the counter and the datapath registers SHALL reside in bin2bcd_seq; no other sub-modules.

Verification
REQ-031 WIDTH=8: bin=0, in_valid for 1 cycle, out_ready=1 -> out_valid high exactly 8 cycles after accept, bcd=12'h000, 1-cycle pulse.
REQ-032 WIDTH=8: bin=255 -> bcd=12'h255; bin=99 -> bcd=12'h099; bin=100 -> bcd=12'h100.
REQ-033 Backpressure: out_ready=0 for 5 DONE cycles then 1 -> out_valid high 6 cycles, bcd constant, in_ready=0 throughout, then IDLE.
REQ-034 in_valid with bin=7 asserted during SHIFT of a conversion of bin=42 -> result 12'h042; 7 is not converted and no extra out_valid occurs.
REQ-035 rst pulsed on the 4th SHIFT cycle of bin=200 -> next cycle IDLE, bcd=0, no out_valid; a subsequent bin=13 -> 12'h013.
REQ-036 WIDTH=16, DIGITS=5: bin=65535 -> bcd=20'h65535 after 16 cycles; an exhaustive sweep 0-255 at WIDTH=8 matches a reference model.
